subbytes_arbiter: RTL and testbench

Sequencer and arbiter that time-shares one 32-bit combinational SubBytes unit (four composite-field S-boxes) between two requesters:
- the round datapath, which submits a 128-bit state processed as four 32-bit words;
- key expansion, which submits single 32-bit words.

It owns the SubBytes input bus, captures its output into result registers, and returns results with valid pulses. It sits between the round controller, the key schedule and the shared SubBytes instance in the AES core.

---
 rtl/subbytes_arb_pkg.sv | 19 +
 rtl/subbytes_arbiter_if.sv | 33 +++
 rtl/subbytes_arb_rr.sv | 26 ++
 rtl/subbytes_arbiter.sv | 151 +++++++++++++++
 tb/tb_subbytes_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/subbytes_arb_pkg.sv
// Shared types and constants for the SubBytes arbiter.
// Build option SUBBYTES_ARB_PIPE_EN is consumed by subbytes_arbiter.
package subbytes_arb_pkg;

   localparam int WORD_W      = 32;
   localparam int NWORDS_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ST_RUN = 2'd1,
      KS_RUN = 2'd2
   } state_t;

   typedef enum logic {
      GNT_ST = 1'b0,
      GNT_KS = 1'b1
   } grant_t;

endpackage

// File: rtl/subbytes_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared SubBytes unit.
// The slave side is the arbiter; the master side is the surrounding core.
import subbytes_arb_pkg::*;

interface subbytes_arbiter_if #(parameter int NWORDS = NWORDS_DFLT);

   logic                       st_req;
   logic [WORD_W*NWORDS-1:0]   st_data;
   logic                       st_ack;
   logic                       st_res_valid;
   logic [WORD_W*NWORDS-1:0]   st_res;
   logic                       ks_req;
   logic [WORD_W-1:0]          ks_data;
   logic                       ks_ack;
   logic                       ks_res_valid;
   logic [WORD_W-1:0]          ks_res;
   logic [WORD_W-1:0]          sb_x;
   logic [WORD_W-1:0]          sb_y;
   logic                       busy;

   modport slave (
      input  st_req, st_data, ks_req, ks_data, sb_y,
      output st_ack, st_res_valid, st_res, ks_ack, ks_res_valid, ks_res,
             sb_x, busy
   );

   modport master (
      output st_req, st_data, ks_req, ks_data, sb_y,
      input  st_ack, st_res_valid, st_res, ks_ack, ks_res_valid, ks_res,
             sb_x, busy
   );

endinterface

// File: rtl/subbytes_arb_rr.sv
// Two-way round-robin picker: on a tie, the requester not granted last wins.
// o_gnt is one-hot: bit 0 = state datapath, bit 1 = key expansion.
import subbytes_arb_pkg::*;

module subbytes_arb_rr (
   input  logic       i_req_st,
   input  logic       i_req_ks,
   input  grant_t     i_last,
   input  logic       i_en,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (i_req_st && i_req_ks) begin
            o_gnt = (i_last == GNT_ST) ? 2'b10 : 2'b01;
         end else if (i_req_st) begin
            o_gnt = 2'b01;
         end else if (i_req_ks) begin
            o_gnt = 2'b10;
         end
      end
   end

endmodule

// File: rtl/subbytes_arbiter.sv
// Time-shares one 32-bit SubBytes unit between the round datapath and key expansion.
// Define SUBBYTES_ARB_PIPE_EN to register sb_y before capture (two cycles per word).
import subbytes_arb_pkg::*;

// state  | meaning
// IDLE   | arbitrating; sb_x = 0; acks and result-valid pulses appear here
// ST_RUN | feeding state words 0..NWORDS-1 through the S-boxes
// KS_RUN | feeding the single key-expansion word
module subbytes_arbiter #(
   parameter int NWORDS = NWORDS_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   subbytes_arbiter_if.slave bus
);

   localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int DW = WORD_W * NWORDS;

   state_t              r_state;
   state_t              w_state_nxt;
   grant_t              r_last;
   logic [CW-1:0]       r_cnt;
   logic [DW-1:0]       r_op;
   logic [DW-1:0]       r_st_res;
   logic [WORD_W-1:0]   r_ks_res;
   logic                r_st_vld;
   logic                r_ks_vld;

   logic [1:0]          w_gnt;
   logic                w_arb_en;
   logic                w_cap;
   logic                w_last_word;
   logic [WORD_W-1:0]   w_cap_y;
   logic [WORD_W-1:0]   w_sb_x;

`ifdef SUBBYTES_ARB_PIPE_EN
   // Phase 0 registers sb_y, phase 1 captures it; sb_x is held across both.
   logic [WORD_W-1:0]   r_sb_y;
   logic                r_ph;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sb_y <= '0;
         r_ph   <= 1'b0;
      end else begin
         r_sb_y <= bus.sb_y;
         r_ph   <= (r_state == IDLE) ? 1'b0 : ~r_ph;
      end
   end

   assign w_cap   = r_ph;
   assign w_cap_y = r_sb_y;
`else
   assign w_cap   = 1'b1;
   assign w_cap_y = bus.sb_y;
`endif

   assign w_arb_en    = rst_n && (r_state == IDLE);
   assign w_last_word = (r_cnt == CW'(NWORDS - 1));

   subbytes_arb_rr u_rr (
      .i_req_st (bus.st_req),
      .i_req_ks (bus.ks_req),
      .i_last   (r_last),
      .i_en     (w_arb_en),
      .o_gnt    (w_gnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sb_x      = '0;
      case (r_state)
         IDLE: begin
            if (w_gnt[1]) begin
               w_state_nxt = KS_RUN;
            end else if (w_gnt[0]) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_sb_x = r_op[int'(r_cnt)*WORD_W +: WORD_W];
            if (w_cap && w_last_word) begin
               w_state_nxt = IDLE;
            end
         end
         KS_RUN: begin
            w_sb_x = r_op[WORD_W-1:0];
            if (w_cap) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last   <= GNT_ST;
         r_cnt    <= '0;
         r_op     <= '0;
         r_st_res <= '0;
         r_ks_res <= '0;
         r_st_vld <= 1'b0;
         r_ks_vld <= 1'b0;
      end else begin
         r_st_vld <= 1'b0;
         r_ks_vld <= 1'b0;
         if (w_gnt[0]) begin
            r_op   <= bus.st_data;
            r_cnt  <= '0;
            r_last <= GNT_ST;
         end else if (w_gnt[1]) begin
            r_op   <= DW'(bus.ks_data);
            r_cnt  <= '0;
            r_last <= GNT_KS;
         end
         // Counter parks on the last word; the next grant clears it.
         if (r_state == ST_RUN && w_cap) begin
            r_st_res[int'(r_cnt)*WORD_W +: WORD_W] <= w_cap_y;
            if (w_last_word) begin
               r_st_vld <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         if (r_state == KS_RUN && w_cap) begin
            r_ks_res <= w_cap_y;
            r_ks_vld <= 1'b1;
         end
      end
   end

   assign bus.st_ack       = w_gnt[0];
   assign bus.ks_ack       = w_gnt[1];
   assign bus.st_res_valid = r_st_vld;
   assign bus.ks_res_valid = r_ks_vld;
   assign bus.st_res       = r_st_res;
   assign bus.ks_res       = r_ks_res;
   assign bus.sb_x         = w_sb_x;
   assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_subbytes_arbiter.sv
// Bench for subbytes_arbiter: GF(2^8) S-box model drives sb_y, and a schedule
// model of grants and result timing is compared against the DUT every cycle.
import subbytes_arb_pkg::*;

module tb_subbytes_arbiter;

   localparam int NW = NWORDS_DFLT;
`ifdef SUBBYTES_ARB_PIPE_EN
   localparam int LAT_ST = 2*NW + 1;
   localparam int LAT_KS = 3;
`else
   localparam int LAT_ST = NW + 1;
   localparam int LAT_KS = 2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc_n = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   subbytes_arbiter_if #(.NWORDS(NW)) bus ();

   subbytes_arbiter #(.NWORDS(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] base;
      logic [7:0] e;
      logic [7:0] t;
      logic [7:0] s;
      r = 8'h00;
      if (b != 8'h00) begin
         r = 8'h01;
         base = b;
         e = 8'd254;
         for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
         end
      end
      t = r;
      s = r;
      for (int i = 0; i < 4; i++) begin
         t = {t[6:0], t[7]};
         s = s ^ t;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [WORD_W*NW-1:0] sub_state(input logic [WORD_W*NW-1:0] d);
      logic [WORD_W*NW-1:0] r;
      r = '0;
      for (int i = 0; i < NW; i++) r[32*i +: 32] = sub_word(d[32*i +: 32]);
      return r;
   endfunction

   assign bus.sb_y = sub_word(bus.sb_x);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc_n, act, exp);
   endtask

   // ---------------- schedule model ----------------
   bit              armed = 1'b0;
   int              free_at, st_vld_at, ks_vld_at, op_t;
   bit              op_ks, last_ks;
   logic [127:0]    op_data, st_pend, st_res_m;
   logic [31:0]     ks_pend, ks_res_m;

   task automatic model_reset(input int c);
      free_at   = c + 1;
      st_vld_at = -1;
      ks_vld_at = -1;
      op_t      = -1000;
      op_ks     = 1'b0;
      last_ks   = 1'b0;
      op_data   = '0;
      st_res_m  = '0;
      ks_res_m  = '0;
   endtask

   always @(negedge clk) begin
      int c, d, w;
      bit e_busy, e_sta, e_ksa, e_stv, e_ksv, st_burst;
      logic [31:0] e_sbx;
      c = cyc_n;
      if (!armed) begin
         if (!rst_n) begin
            model_reset(c);
            armed = 1'b1;
         end
      end else begin
         e_busy = (c < free_at);
         e_sbx = 32'h0;
         d = c - op_t;
         if (e_busy && d >= 1) begin
            if (op_ks) e_sbx = op_data[31:0];
            else begin
`ifdef SUBBYTES_ARB_PIPE_EN
               w = (d - 1) / 2;
`else
               w = d - 1;
`endif
               e_sbx = op_data[32*w +: 32];
            end
         end
         st_burst = e_busy && !op_ks;
         e_stv = (c == st_vld_at);
         e_ksv = (c == ks_vld_at);
         if (e_stv) st_res_m = st_pend;
         if (e_ksv) ks_res_m = ks_pend;
         e_sta = 1'b0;
         e_ksa = 1'b0;
         if (rst_n && !e_busy) begin
            if (bus.st_req && bus.ks_req) begin
               e_ksa = !last_ks;
               e_sta = last_ks;
            end else begin
               e_sta = bus.st_req;
               e_ksa = bus.ks_req;
            end
            if (e_sta) begin
               op_t = c; op_ks = 1'b0; op_data = bus.st_data; last_ks = 1'b0;
               free_at = c + LAT_ST; st_vld_at = c + LAT_ST;
               st_pend = sub_state(bus.st_data);
            end else if (e_ksa) begin
               op_t = c; op_ks = 1'b1; op_data = {96'h0, bus.ks_data}; last_ks = 1'b1;
               free_at = c + LAT_KS; ks_vld_at = c + LAT_KS;
               ks_pend = sub_word(bus.ks_data);
            end
         end
         chk("st_ack", bus.st_ack, e_sta);
         chk("ks_ack", bus.ks_ack, e_ksa);
         chk("busy", bus.busy, e_busy);
         chk("sb_x", bus.sb_x, e_sbx);
         chk("st_res_valid", bus.st_res_valid, e_stv);
         chk("ks_res_valid", bus.ks_res_valid, e_ksv);
         chk("ks_res", bus.ks_res, ks_res_m);
         if (!st_burst) chk("st_res", bus.st_res, st_res_m);
         if (!rst_n) model_reset(c);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input int sel, input string name, output int at);
      bit hit;
      hit = 1'b0;
      at = -1;
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0: hit = bus.st_ack;
            1: hit = bus.ks_ack;
            2: hit = bus.st_res_valid;
            default: hit = bus.ks_res_valid;
         endcase
         if (hit) at = cyc_n;
      end
      if (!hit) begin
         n_checks++;
         $display("FAIL timeout_%s: got no event expected one within 60 cycles", name);
      end
   endtask

   initial begin
      int t_a, t_v, t_b, n_hits;
      int g_t[$];
      bit g_ks[$];
      bus.st_req = 1'b0; bus.ks_req = 1'b0;
      bus.st_data = '0;  bus.ks_data = '0;

      chk("model_sbox_key", sub_word(32'h0053_01FF), 32'h63ED_7C16);
      chk("model_sbox_zero", sub_word(32'h0), 32'h6363_6363);

      step(); step();
      rst_n = 1'b1;
      step();

      // single key word
      bus.ks_req = 1'b1; bus.ks_data = 32'h0053_01FF;
      wait_for(1, "ks_ack1", t_a);
      step(); bus.ks_req = 1'b0;
      wait_for(3, "ks_vld1", t_v);
      chk("ks_latency", t_v - t_a, LAT_KS);
      chk("ks_res_lit", bus.ks_res, 32'h63ED_7C16);

      // zero state
      step();
      bus.st_req = 1'b1; bus.st_data = '0;
      wait_for(0, "st_ack1", t_a);
      step(); bus.st_req = 1'b0;
      wait_for(2, "st_vld1", t_v);
      chk("st_latency", t_v - t_a, LAT_ST);
      chk("st_res_lit", bus.st_res, {4{32'h6363_6363}});

      // simultaneous requests: key side wins the tie
      step(); step();
      bus.st_req = 1'b1; bus.st_data = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      bus.ks_req = 1'b1; bus.ks_data = 32'h0102_0304;
      wait_for(1, "ks_ack_tie", t_a);
      step(); bus.ks_req = 1'b0;
      wait_for(0, "st_ack_tie", t_b);
      chk("tie_st_ack_cycle", t_b - t_a, LAT_KS);
      step(); bus.st_req = 1'b0;
      wait_for(2, "st_vld_tie", t_v);
      chk("tie_st_res", bus.st_res, sub_state(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF));

      // both held: alternating grants with no idle gap
      step(); step();
      bus.st_req = 1'b1; bus.st_data = 128'hDEAD_BEEF_0F1E_2D3C_4B5A_6978_8796_A5B4;
      bus.ks_req = 1'b1; bus.ks_data = 32'hC3A5_5A3C;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (bus.ks_ack) begin g_t.push_back(cyc_n); g_ks.push_back(1'b1); end
         if (bus.st_ack) begin g_t.push_back(cyc_n); g_ks.push_back(1'b0); end
      end
      step(); bus.st_req = 1'b0; bus.ks_req = 1'b0;
      chk("rr_grant_count_ge4", g_t.size() >= 4, 1'b1);
      if (g_t.size() >= 4) begin
         chk("rr_g0_ks", g_ks[0], 1'b1);
         chk("rr_g1_st", g_ks[1], 1'b0);
         chk("rr_g2_ks", g_ks[2], 1'b1);
         chk("rr_g3_st", g_ks[3], 1'b0);
         chk("rr_gap01", g_t[1] - g_t[0], LAT_KS);
         chk("rr_gap12", g_t[2] - g_t[1], LAT_ST);
         chk("rr_gap23", g_t[3] - g_t[2], LAT_KS);
      end
      repeat (2*LAT_ST) step();

      // reset in the third ST_RUN cycle
      bus.st_req = 1'b1; bus.st_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      wait_for(0, "st_ack_rst", t_a);
      step(); bus.st_req = 1'b0;
      step();
      step(); rst_n = 1'b0;
      step(); rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_st_res", bus.st_res, 128'h0);
      chk("rst_st_vld", bus.st_res_valid, 1'b0);
      n_hits = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.st_res_valid) n_hits++;
      end
      chk("rst_no_vld", n_hits, 0);
      step();
      bus.st_req = 1'b1;
      wait_for(0, "st_ack_rereq", t_a);
      step(); bus.st_req = 1'b0;
      wait_for(2, "st_vld_rereq", t_v);
      chk("rereq_st_res", bus.st_res, sub_state(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));

      // key request withdrawn while the state burst is running
      step();
      bus.st_req = 1'b1; bus.st_data = 128'h1;
      wait_for(0, "st_ack_drop", t_a);
      step(); bus.st_req = 1'b0; bus.ks_req = 1'b1; bus.ks_data = 32'h5555_AAAA;
      step();
      step(); bus.ks_req = 1'b0;
      n_hits = 0;
      for (int i = 0; i < 2*LAT_ST; i++) begin
         @(negedge clk);
         if (bus.ks_ack || bus.ks_res_valid) n_hits++;
      end
      chk("drop_no_ks", n_hits, 0);

      repeat (4) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
